// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: bitslip-driven word alignment on control tokens, then token/data decode.
// Optional lock-loss counter on o_err_count is built when TMDS_DEC_ERR_CNT_EN is defined.
module tmds_channel_decoder #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_WAIT      = 4,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic        i_pix_clk,
  input  logic        i_rst_n,
  input  logic [9:0]  i_tmds_word,
  output logic        o_bitslip,
  output logic        o_aligned,
  output logic        o_de,
  output logic [7:0]  o_data,
  output logic [1:0]  o_ctrl,
  output logic [3:0]  o_slip_count,
  output logic [15:0] o_err_count
);
  localparam int RUN_W = $clog2(CTRL_RUN + 1);
  localparam int ST_W  = $clog2(SEARCH_TIMEOUT);
  localparam int SW_W  = $clog2(SLIP_WAIT + 1);
  localparam int LT_W  = $clog2(LOCK_TIMEOUT);

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  // Returns {is_token, ctrl[1:0]}.
  function automatic logic [2:0] token_lookup(input logic [9:0] w);
    case (w)
      10'h354: token_lookup = 3'b1_00;
      10'h0AB: token_lookup = 3'b1_01;
      10'h154: token_lookup = 3'b1_10;
      10'h2AB: token_lookup = 3'b1_11;
      default: token_lookup = 3'b0_00;
    endcase
  endfunction

  function automatic logic [7:0] data_decode(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q    = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  state_t           state_r, next_state_s;
  logic [RUN_W-1:0] run_r, run_next_s;
  logic [ST_W-1:0]  timer_r, timer_next_s;
  logic [SW_W-1:0]  wait_r, wait_next_s;
  logic [LT_W-1:0]  lock_r, lock_next_s;
  logic             slip_pulse_s, lock_event_s, lock_loss_s;
  logic [2:0]       tok_s;
  logic [7:0]       data_s;
  logic             bitslip_r, aligned_r, de_r;
  logic [7:0]       data_r;
  logic [1:0]       ctrl_r;
  logic [3:0]       slip_cnt_r;

  // Word classification for the current input.
  always_comb begin
    tok_s  = token_lookup(i_tmds_word);
    data_s = data_decode(i_tmds_word);
  end

  // Next-state logic; lock wins over a coincident search timeout.
  always_comb begin
    next_state_s = state_r;
    run_next_s   = run_r;
    timer_next_s = timer_r;
    wait_next_s  = wait_r;
    lock_next_s  = lock_r;
    slip_pulse_s = 1'b0;
    lock_event_s = 1'b0;
    lock_loss_s  = 1'b0;
    case (state_r)
      ST_SEARCH: begin
        if (tok_s[2] && (run_r >= RUN_W'(CTRL_RUN - 1))) begin
          next_state_s = ST_LOCKED;
          run_next_s   = '0;
          timer_next_s = '0;
          lock_next_s  = '0;
          lock_event_s = 1'b1;
        end else if (timer_r == ST_W'(SEARCH_TIMEOUT - 1)) begin
          next_state_s = ST_SLIP_WAIT;
          run_next_s   = '0;
          timer_next_s = '0;
          wait_next_s  = '0;
          slip_pulse_s = 1'b1;
        end else begin
          run_next_s   = tok_s[2] ? (run_r + RUN_W'(1)) : '0;
          timer_next_s = (run_r != '0) ? '0 : (timer_r + ST_W'(1));
        end
      end
      ST_SLIP_WAIT: begin
        run_next_s = '0;
        if (wait_r >= SW_W'(SLIP_WAIT - 1)) begin
          next_state_s = ST_SEARCH;
          wait_next_s  = '0;
          timer_next_s = '0;
        end else begin
          wait_next_s = wait_r + SW_W'(1);
        end
      end
      ST_LOCKED: begin
        if (tok_s[2]) begin
          lock_next_s = '0;
        end else if (lock_r == LT_W'(LOCK_TIMEOUT - 1)) begin
          next_state_s = ST_SEARCH;
          lock_next_s  = '0;
          run_next_s   = '0;
          timer_next_s = '0;
          lock_loss_s  = 1'b1;
        end else begin
          lock_next_s = lock_r + LT_W'(1);
        end
      end
      default: begin
        next_state_s = ST_SEARCH;
        run_next_s   = '0;
        timer_next_s = '0;
        wait_next_s  = '0;
        lock_next_s  = '0;
      end
    endcase
  end

  // State, counters and registered outputs; output gating follows the state being entered.
  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_SEARCH;
      run_r      <= '0;
      timer_r    <= '0;
      wait_r     <= '0;
      lock_r     <= '0;
      bitslip_r  <= 1'b0;
      aligned_r  <= 1'b0;
      de_r       <= 1'b0;
      data_r     <= 8'h00;
      ctrl_r     <= 2'b00;
      slip_cnt_r <= 4'd0;
    end else begin
      state_r   <= next_state_s;
      run_r     <= run_next_s;
      timer_r   <= timer_next_s;
      wait_r    <= wait_next_s;
      lock_r    <= lock_next_s;
      bitslip_r <= slip_pulse_s;
      aligned_r <= (next_state_s == ST_LOCKED);
      if (lock_event_s) begin
        slip_cnt_r <= 4'd0;
      end else if (slip_pulse_s) begin
        slip_cnt_r <= (slip_cnt_r == 4'd9) ? 4'd0 : (slip_cnt_r + 4'd1);
      end else begin
        slip_cnt_r <= slip_cnt_r;
      end
      if (next_state_s != ST_LOCKED) begin
        de_r   <= 1'b0;
        data_r <= 8'h00;
        ctrl_r <= 2'b00;
      end else if (tok_s[2]) begin
        de_r   <= 1'b0;
        data_r <= 8'h00;
        ctrl_r <= tok_s[1:0];
      end else begin
        de_r   <= 1'b1;
        data_r <= data_s;
        ctrl_r <= ctrl_r;
      end
    end
  end

`ifdef TMDS_DEC_ERR_CNT_EN
  logic [15:0] err_cnt_r;

  // Lock-loss counter, saturating, cleared only by reset.
  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt_r <= 16'h0000;
    end else if (lock_loss_s && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'h0001;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign o_err_count = err_cnt_r;
`else
  assign o_err_count = 16'h0000;
`endif

  assign o_bitslip    = bitslip_r;
  assign o_aligned    = aligned_r;
  assign o_de         = de_r;
  assign o_data       = data_r;
  assign o_ctrl       = ctrl_r;
  assign o_slip_count = slip_cnt_r;
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: lock, decode, lock loss, run reset, bitslip search, reset mid-pulse.
module tb_tmds_channel_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  word = 10'h000;
  logic        o_bitslip, o_aligned, o_de;
  logic [7:0]  o_data;
  logic [1:0]  o_ctrl;
  logic [3:0]  o_slip_count;
  logic [15:0] o_err_count;

  int checks = 0;
  int passes = 0;
  int pulses = 0;

  typedef struct {
    string      tag;
    logic       al;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
  } exp_t;
  exp_t sb[$];

  tmds_channel_decoder dut (
    .i_pix_clk   (clk),
    .i_rst_n     (rst_n),
    .i_tmds_word (word),
    .o_bitslip   (o_bitslip),
    .o_aligned   (o_aligned),
    .o_de        (o_de),
    .o_data      (o_data),
    .o_ctrl      (o_ctrl),
    .o_slip_count(o_slip_count),
    .o_err_count (o_err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_bitslip) pulses <= pulses + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one word; when push is set, queue the expected outputs and compare one cycle later.
  task automatic step(input logic [9:0] w, input bit push, input string tag,
                      input logic al, input logic de, input logic [7:0] data, input logic [1:0] ctrl);
    exp_t e;
    word = w;
    if (push) begin
      e.tag = tag; e.al = al; e.de = de; e.data = data; e.ctrl = ctrl;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (push) begin
      e = sb.pop_front();
      chk({e.tag, ".aligned"}, {31'd0, o_aligned}, {31'd0, e.al});
      chk({e.tag, ".de"},      {31'd0, o_de},      {31'd0, e.de});
      chk({e.tag, ".data"},    {24'd0, o_data},    {24'd0, e.data});
      chk({e.tag, ".ctrl"},    {30'd0, o_ctrl},    {30'd0, e.ctrl});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    word  = 10'h000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [9:0] rot(input logic [9:0] w, input int k);
    logic [19:0] d;
    d = {w, w};
    return d[k +: 10];
  endfunction

  initial begin
    int p0, phase, cyc, n, first, prev, bad, sc_before;
    logic [15:0] exp_err;
`ifdef TMDS_DEC_ERR_CNT_EN
    exp_err = 16'h0001;
`else
    exp_err = 16'h0000;
`endif

    do_reset();
    chk("reset.bitslip", {31'd0, o_bitslip}, 32'd0);
    chk("reset.aligned", {31'd0, o_aligned}, 32'd0);
    chk("reset.de", {31'd0, o_de}, 32'd0);
    chk("reset.data", {24'd0, o_data}, 32'd0);
    chk("reset.ctrl", {30'd0, o_ctrl}, 32'd0);
    chk("reset.slip_count", {28'd0, o_slip_count}, 32'd0);
    chk("reset.err_count", {16'd0, o_err_count}, 32'd0);

    p0 = pulses;
    for (int i = 0; i < 7; i++) step(10'h354, 1'b1, "lock.pre", 1'b0, 1'b0, 8'h00, 2'b00);
    step(10'h354, 1'b1, "lock.8th", 1'b1, 1'b0, 8'h00, 2'b00);
    chk("lock.no_bitslip", pulses - p0, 32'd0);
    chk("lock.slip_count", {28'd0, o_slip_count}, 32'd0);

    step(10'h100, 1'b1, "dec.0x100", 1'b1, 1'b1, 8'h00, 2'b00);
    step(10'h1FF, 1'b1, "dec.0x1FF", 1'b1, 1'b1, 8'h01, 2'b00);
    step(10'h2AB, 1'b1, "dec.tok11", 1'b1, 1'b0, 8'h00, 2'b11);
    step(10'h200, 1'b1, "dec.0x200", 1'b1, 1'b1, 8'hFF, 2'b11);
    step(10'h2F0, 1'b1, "dec.0x2F0", 1'b1, 1'b1, 8'hEF, 2'b11);
    step(10'h154, 1'b1, "dec.tok10", 1'b1, 1'b0, 8'h00, 2'b10);
    step(10'h0AB, 1'b1, "dec.tok01", 1'b1, 1'b0, 8'h00, 2'b01);

    for (int i = 1; i < 4096; i++) step(10'h100, (i == 4095), "loss.4095", 1'b1, 1'b1, 8'h00, 2'b01);
    step(10'h100, 1'b1, "loss.4096", 1'b0, 1'b0, 8'h00, 2'b00);
    chk("loss.err_count", {16'd0, o_err_count}, {16'd0, exp_err});

    do_reset();
    chk("run.err_cleared", {16'd0, o_err_count}, 32'd0);
    for (int i = 0; i < 7; i++) step(10'h354, (i == 6), "run.first7", 1'b0, 1'b0, 8'h00, 2'b00);
    step(10'h100, 1'b1, "run.break", 1'b0, 1'b0, 8'h00, 2'b00);
    for (int i = 0; i < 7; i++) step(10'h354, (i == 6), "run.second7", 1'b0, 1'b0, 8'h00, 2'b00);
    step(10'h354, 1'b1, "run.complete", 1'b1, 1'b0, 8'h00, 2'b00);

    // Deserializer model: each bitslip advances the sampling phase of a repeating 0x354 stream.
    do_reset();
    phase = 3; cyc = 0; n = 0; first = 0; prev = 0; bad = 0; sc_before = 0;
    while (!o_aligned && cyc < 20000) begin
      word = rot(10'h354, phase);
      @(posedge clk);
      #1;
      cyc++;
      if (o_bitslip) begin
        n++;
        if (n == 1) first = cyc;
        else if (cyc - prev != 2052) bad++;
        prev = cyc;
        phase = (phase + 1) % 10;
        sc_before = int'(o_slip_count);
      end
    end
    chk("slip.locked", {31'd0, o_aligned}, 32'd1);
    chk("slip.pulses", n, 32'd7);
    chk("slip.first_at", first, 32'd2048);
    chk("slip.bad_intervals", bad, 32'd0);
    chk("slip.count_before_lock", sc_before, 32'd7);
    chk("slip.lock_delay", cyc - prev, 32'd12);
    chk("slip.count_at_lock", {28'd0, o_slip_count}, 32'd0);

    do_reset();
    word = 10'h000;
    cyc = 0;
    while (!o_bitslip && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rstpulse.seen", {31'd0, o_bitslip}, 32'd1);
    chk("rstpulse.slip_count_pre", {28'd0, o_slip_count}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstpulse.bitslip", {31'd0, o_bitslip}, 32'd0);
    chk("rstpulse.aligned", {31'd0, o_aligned}, 32'd0);
    chk("rstpulse.slip_count", {28'd0, o_slip_count}, 32'd0);
    #3;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
